// File: rtl/term_pkg.sv
// Shared types and constants for the VGA text console write controller.
package term_pkg;

  localparam int DEF_COLS = 64;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_BS     = 8'h08;
  localparam logic [7:0] ASCII_PROMPT = 8'h3E;
  localparam logic [7:0] ASCII_BLANK  = 8'h00;

  typedef enum logic [2:0] {
    CLEAR,
    PROMPT,
    IDLE,
    SCROLL_CP,
    SCROLL_CLR
  } term_state_e;

  function automatic logic [11:0] vram_addr(input logic [5:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/term_scroller.sv
// VRAM copy engine (rows 1..ROWS-1 shifted up one row) followed by a single-row clear.
// i_copy=0 runs only the row clear on i_clr_row.
module term_scroller
  import term_pkg::*;
#(
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_copy,
  input  logic [5:0]  i_clr_row,
  output logic [11:0] o_raddr,
  input  logic [7:0]  i_rdata,
  output logic        o_we,
  output logic [11:0] o_waddr,
  output logic [7:0]  o_wdata,
  output logic        o_cp_done,
  output logic        o_done
);
  localparam logic [11:0] RD_LAST = {6'(ROWS - 1), 6'd63};

  logic        r_cp;
  logic        r_pend;
  logic        r_clr;
  logic [11:0] r_rd;
  logic [11:0] r_wa;
  logic [5:0]  r_col;
  logic [5:0]  r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cp   <= 1'b0;
      r_pend <= 1'b0;
      r_clr  <= 1'b0;
      r_rd   <= '0;
      r_wa   <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else begin
      // read stage -> write stage: data returns one cycle after the read
      r_pend <= r_cp;
      r_wa   <= r_rd - 12'd64;
      if (i_start) begin
        r_row <= i_clr_row;
        r_col <= '0;
        r_cp  <= i_copy;
        r_clr <= !i_copy;
        r_rd  <= vram_addr(6'd1, 6'd0);
      end else begin
        if (r_cp) begin
          r_rd <= r_rd + 12'd1;
          if (r_rd == RD_LAST) r_cp <= 1'b0;
        end
        if (r_pend && !r_cp) begin
          r_clr <= 1'b1;
          r_col <= '0;
        end else if (r_clr) begin
          r_col <= r_col + 6'd1;
          if (r_col == 6'd63) r_clr <= 1'b0;
        end
      end
    end
  end

  assign o_raddr   = r_cp ? r_rd : 12'd0;
  assign o_we      = r_pend | r_clr;
  assign o_waddr   = r_pend ? r_wa : vram_addr(r_row, r_col);
  assign o_wdata   = r_pend ? i_rdata : ASCII_BLANK;
  assign o_cp_done = r_pend & ~r_cp;
  assign o_done    = r_clr & (r_col == 6'd63);

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal write controller: cursor tracking and sequencing of all VRAM writes.
// Optional TERM_SCROLL_EN: scroll the screen up at the bottom instead of wrapping to row 0.
module text_term_ctrl
  import term_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic        key_ready,
  output logic        vram_we,
  output logic [11:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic [11:0] vram_raddr,
  input  logic [7:0]  vram_rdata,
  output logic [6:0]  cur_x,
  output logic [6:0]  cur_y,
  output logic        busy
);
`ifdef TERM_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
`else
  localparam bit SCROLL_EN = 1'b0;
`endif
  localparam logic [6:0]  X_LAST   = 7'(COLS - 1);
  localparam logic [6:0]  Y_LAST   = 7'(ROWS - 1);
  localparam logic [11:0] CLR_LAST = {6'(ROWS - 1), 6'd63};

  term_state_e r_state;
  logic [11:0] r_clr_addr;
  logic [6:0]  r_cur_x, r_cur_y;
  logic        r_after_cr;
  logic        r_we;
  logic [11:0] r_waddr;
  logic [7:0]  r_wdata;

  logic        w_accept, w_printable, w_is_cr, w_is_bs, w_x_last, w_y_last;
  logic        w_scr_start, w_scr_copy;
  logic [5:0]  w_scr_row;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic        w_scr_we, w_scr_cp_done, w_scr_done;
  logic [11:0] w_scr_waddr, w_scr_raddr;
  logic [7:0]  w_scr_wdata;

  assign w_accept    = key_valid && (r_state == IDLE);
  assign w_printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign w_is_cr     = (key_ascii == ASCII_CR);
  assign w_is_bs     = (key_ascii == ASCII_BS);
  assign w_x_last    = (r_cur_x == X_LAST);
  assign w_y_last    = (r_cur_y == Y_LAST);
  assign w_scr_start = w_accept && w_y_last && ((w_printable && w_x_last) || w_is_cr);
  assign w_scr_copy  = SCROLL_EN;
  assign w_scr_row   = SCROLL_EN ? Y_LAST[5:0] : 6'd0;

  term_scroller #(.ROWS(ROWS)) u_scroller (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_scr_start),
    .i_copy    (w_scr_copy),
    .i_clr_row (w_scr_row),
    .o_raddr   (w_scr_raddr),
    .i_rdata   (vram_rdata),
    .o_we      (w_scr_we),
    .o_waddr   (w_scr_waddr),
    .o_wdata   (w_scr_wdata),
    .o_cp_done (w_scr_cp_done),
    .o_done    (w_scr_done)
  );

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = ASCII_BLANK;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
      end
      PROMPT: begin
        w_we    = 1'b1;
        w_waddr = vram_addr(r_cur_y[5:0], 6'd0);
        w_wdata = ASCII_PROMPT;
      end
      IDLE: begin
        if (w_accept && w_printable) begin
          w_we    = 1'b1;
          w_waddr = vram_addr(r_cur_y[5:0], r_cur_x[5:0]);
          w_wdata = key_ascii;
        end else if (w_accept && w_is_bs && r_cur_x != 7'd0) begin
          w_we    = 1'b1;
          w_waddr = vram_addr(r_cur_y[5:0], r_cur_x[5:0] - 6'd1);
        end else if (w_accept && w_is_bs && r_cur_y != 7'd0) begin
          w_we    = 1'b1;
          w_waddr = vram_addr(r_cur_y[5:0] - 6'd1, X_LAST[5:0]);
        end
      end
      default: begin
        w_we    = w_scr_we;
        w_waddr = w_scr_waddr;
        w_wdata = w_scr_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_after_cr <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we    <= w_we;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
      case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 12'd1;
          if (r_clr_addr == CLR_LAST) r_state <= PROMPT;
        end
        PROMPT: begin
          r_cur_x <= 7'd2;
          r_state <= IDLE;
        end
        IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              if (w_x_last) begin
                r_cur_x    <= '0;
                r_after_cr <= 1'b0;
                if (!w_y_last) r_cur_y <= r_cur_y + 7'd1;
                else if (!SCROLL_EN) r_cur_y <= '0;
              end else begin
                r_cur_x <= r_cur_x + 7'd1;
              end
            end else if (w_is_cr) begin
              r_cur_x    <= '0;
              r_after_cr <= 1'b1;
              if (!w_y_last) begin
                r_cur_y <= r_cur_y + 7'd1;
                r_state <= PROMPT;
              end else if (!SCROLL_EN) begin
                r_cur_y <= '0;
              end
            end else if (w_is_bs) begin
              if (r_cur_x != 7'd0) begin
                r_cur_x <= r_cur_x - 7'd1;
              end else if (r_cur_y != 7'd0) begin
                r_cur_x <= X_LAST;
                r_cur_y <= r_cur_y - 7'd1;
              end
            end
            if (w_scr_start) begin
              if (SCROLL_EN) r_state <= SCROLL_CP;
              else           r_state <= SCROLL_CLR;
            end
          end
        end
        SCROLL_CP: begin
          if (w_scr_cp_done) r_state <= SCROLL_CLR;
        end
        SCROLL_CLR: begin
          if (w_scr_done) begin
            if (r_after_cr) r_state <= PROMPT;
            else            r_state <= IDLE;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign key_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign vram_we    = r_we;
  assign vram_waddr = r_waddr;
  assign vram_wdata = r_wdata;
  assign vram_raddr = SCROLL_EN ? w_scr_raddr : 12'd0;
  assign cur_x      = r_cur_x;
  assign cur_y      = r_cur_y;

endmodule

// File: doc/text_term_ctrl.md
# text_term_ctrl

Terminal write controller for the VGA text console. Accepts ASCII bytes from the keyboard path, maintains the cursor, and sequences all writes into the character video RAM that the VGA displayer reads: character placement, carriage return with prompt, backspace, screen clear at reset, and a full-screen scroll when output runs past the bottom row. Cursor position is exported to the displayer for the blinking cursor overlay.

## Interface
Parameters:
- COLS, 64: visible columns. Must be ≤ 64, because the column field is 6 bits.
- ROWS, 30: visible rows. Must be ≤ 64.

Ports:
- clk  in  1  system clock; the same clock as the VRAM write port.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  an ASCII byte is offered.
- key_ascii  in  8  offered byte.
- key_ready  out  1  controller can accept a byte this cycle.
- vram_we  out  1  VRAM write strobe.
- vram_waddr  out  12  write address, {row[5:0], col[5:0]}.
- vram_wdata  out  8  write data.
- vram_raddr  out  12  read address used during scroll. Same address format as vram_waddr.
- vram_rdata  in  8  read data, synchronous, valid 1 cycle after vram_raddr.
- cur_x  out  7  cursor column.
- cur_y  out  7  cursor row.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: CLEAR, PROMPT, IDLE, SCROLL_CP, SCROLL_CLR.
- Reset: all outputs 0, except busy=1. Next state is CLEAR.
- CLEAR writes 0x00 to every address in rows 0..ROWS-1 and columns 0..63, one per cycle. It then goes to PROMPT.
- PROMPT writes 0x3E at (0, cur_y), sets cur_x=2, and goes to IDLE.
- key_ready = (state==IDLE). A byte is accepted when key_valid && key_ready. Handling depends on the byte:
  - 0x20..0x7E: write the byte at (cur_x, cur_y), then cur_x+1. If cur_x was COLS-1: cur_x=0 and cur_y+1. If cur_y was ROWS-1 in that case: go to SCROLL_CP, with cursor ending at (0, ROWS-1).
  - 0x0D: if cur_y<ROWS-1, set cur_y+1 and go to PROMPT. Otherwise go to SCROLL_CP, then PROMPT on row ROWS-1.
  - 0x08: if cur_x>0, set cur_x-1 and write 0x00 there. If cur_x==0 and cur_y>0, move to (COLS-1, cur_y-1) and write 0x00 there. At (0,0): no-op.
  - Any other byte: consumed, no write, no cursor change.
- SCROLL_CP: for every address in rows 1..ROWS-1, cols 0..63, issue a read. One cycle later, write the returned data to the same column in row-1. This is a pipelined one-per-cycle copy.
- SCROLL_CLR: write 0x00 across row ROWS-1, then return to PROMPT (after 0x0D) or to IDLE (after a wrap).
- The cursor never leaves [0,COLS-1]×[0,ROWS-1].

## Timing
- vram_we/waddr/wdata are registered. A write caused by a byte accepted in cycle N is asserted in cycle N+1 for exactly 1 cycle.
- cur_x/cur_y update in cycle N+1.
- key_ready is low from cycle N+1 whenever the byte causes PROMPT or a scroll. For a plain character or backspace, key_ready stays high, giving 1 byte/cycle throughput.
- CLEAR: ROWS×64 cycles, then 1 cycle of PROMPT.
- SCROLL_CP: (ROWS-1)×64 reads, with the last write 1 cycle after the last read. This is 1857 cycles at defaults.
- SCROLL_CLR: 64 cycles.
- rst asserted mid-scroll or mid-clear: abandon the operation, apply reset values, and restart CLEAR on the next cycle.
- key_valid while busy: the byte is held by the source and not dropped. Bytes are never buffered internally.

## Configuration
- TERM_SCROLL_EN defined: scrolling behaves as above.
- TERM_SCROLL_EN undefined: there is no SCROLL_CP. Running past row ROWS-1 wraps the cursor to row 0; SCROLL_CLR then clears row 0 instead of ROWS-1. vram_raddr is tied to 0.

## Structure
- Package term_pkg holds:
  - COLS and ROWS defaults;
  - ASCII_CR=8'h0D, ASCII_BS=8'h08, ASCII_PROMPT=8'h3E, ASCII_BLANK=8'h00;
  - the state enum;
  - a helper that packs {row, col} into a 12-bit VRAM address.
- One sub-module, term_scroller, contains the read/write copy engine and the row clear. It has a start/done handshake and its own VRAM read port and write-request outputs. The top-level module muxes writes from term_scroller and from the character path.

## Test plan
- Reset, then idle. Expected: 1920 writes of 0x00, then a write of 0x3E at address 0x000. cur=(2,0), busy=0 after 1921 cycles.
- Send 'A','B' (0x41, 0x42) back to back. Expected: writes 0x41@0x002 and 0x42@0x003 on consecutive cycles. cur=(4,0), key_ready held high.
- Send 0x08 at (4,0). Expected: write 0x00@0x003, cur=(3,0). Then send 0x0D. Expected: write 0x3E@0x040, cur=(2,1).
- Fill to (63,29) and send 'Z'.
  - TERM_SCROLL_EN defined: expected write 0x5A@{29,63}, then a scroll.
    - Row 28 equals the old row 29, including the 0x5A at col 63.
    - Row 29 is all 0x00.
    - cur=(0,29).
    - busy high for 1857+64 cycles.
  - TERM_SCROLL_EN undefined: expected cur=(0,0), with row 0 cleared.
- Pulse rst midway through SCROLL_CP. Expected: outputs return to reset values on the next cycle and the full CLEAR sequence restarts.
- Hold key_valid with 0x41 while busy. Expected: no acceptance until IDLE, then exactly one write.
